// File: rtl/timebase_scheduler.sv
// timebase_scheduler: derives the display scan strobe, the 1 Hz timekeeping
// enable, the blink level and the adjust-button auto-repeat pulses from one
// clock. A RUN/SET mode freezes the seconds timebase while the time is set.
module timebase_scheduler #(
    parameter int SCAN_DIV      = 500000,
    parameter int SCANS_PER_SEC = 200,
    parameter int HOLD_SCANS    = 200,
    parameter int REPEAT_SCANS  = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic set_mode,
    input  logic adj_req,
    output logic scan_tick,
    output logic sec_tick,
    output logic blink,
    output logic adj_tick,
    output logic in_set
);

    localparam int PW   = $clog2(SCAN_DIV);
    localparam int SW   = $clog2(SCANS_PER_SEC);
    localparam int AMAX = (HOLD_SCANS > REPEAT_SCANS) ? HOLD_SCANS : REPEAT_SCANS;
    localparam int AW   = $clog2(AMAX + 1);

    localparam logic [PW-1:0] PRESC_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST    = SW'(SCANS_PER_SEC - 1);
    localparam logic [SW-1:0] SCAN_HALF_M1 = SW'(SCANS_PER_SEC / 2 - 1);
    localparam logic [AW-1:0] HOLD_LAST    = AW'(HOLD_SCANS - 1);
    localparam logic [AW-1:0] REP_LAST     = AW'(REPEAT_SCANS - 1);

    typedef enum logic {
        M_RUN = 1'b0,
        M_SET = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_HOLD   = 2'd1,
        A_REPEAT = 2'd2
    } adj_t;

    logic [PW-1:0] presc_q, presc_d;
    logic          scan_wrap;
    logic          scan_tick_q, scan_tick_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic          restart_q, restart_d;
    logic          blink_q, blink_d;
    logic          sec_tick_q, sec_tick_d;
    mode_t         mode_q, mode_d;
    logic          in_set_q, in_set_d;
    adj_t          adj_st_q, adj_st_d;
    logic [AW-1:0] adj_cnt_q, adj_cnt_d;
    logic          adj_prev_q, adj_prev_d;
    logic          adj_tick_q, adj_tick_d;
    logic          adj_active;

    // A scan period ends in the cycle the prescaler sits on its last count.
    assign scan_wrap = (presc_q == PRESC_LAST);

    // Free-running prescaler; the scan strobe is registered from its wrap.
    always_comb begin
        presc_d     = scan_wrap ? '0 : presc_q + PW'(1);
        scan_tick_d = scan_wrap;
    end

    // Scan counter, blink and seconds pulse; SET parks the counter at 0 and
    // arms a restart so the first scan strobe back in RUN re-opens the second.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        restart_d  = restart_q;
        blink_d    = blink_q;
        sec_tick_d = 1'b0;
        if (mode_q == M_SET) begin
            scan_cnt_d = '0;
            restart_d  = 1'b1;
        end else if (scan_wrap) begin
            if (restart_q) begin
                scan_cnt_d = '0;
                restart_d  = 1'b0;
            end else if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                blink_d    = ~blink_q;
                sec_tick_d = 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + SW'(1);
                if (scan_cnt_q == SCAN_HALF_M1) begin
                    blink_d = ~blink_q;
                end
            end
        end
    end

    // Mode follows set_mode with one clock of latency; in_set mirrors it.
    always_comb begin
        mode_d   = set_mode ? M_SET : M_RUN;
        in_set_d = set_mode;
    end

    // Adjust FSM: only live while SET is held; leaving SET drops it to idle
    // in the same cycle without a tick.
    always_comb begin
        adj_active = (mode_q == M_SET) && set_mode;
        adj_prev_d = adj_req;
        adj_st_d   = adj_st_q;
        adj_cnt_d  = adj_cnt_q;
        adj_tick_d = 1'b0;
        if (!adj_active) begin
            adj_st_d  = A_IDLE;
            adj_cnt_d = '0;
        end else begin
            case (adj_st_q)
                A_IDLE: begin
                    if (adj_req && !adj_prev_q) begin
                        adj_tick_d = 1'b1;
                        adj_cnt_d  = '0;
                        adj_st_d   = A_HOLD;
                    end
                end
                A_HOLD: begin
                    if (!adj_req) begin
                        adj_st_d  = A_IDLE;
                        adj_cnt_d = '0;
                    end else if (scan_wrap) begin
                        if (adj_cnt_q == HOLD_LAST) begin
                            adj_tick_d = 1'b1;
                            adj_cnt_d  = '0;
                            adj_st_d   = A_REPEAT;
                        end else begin
                            adj_cnt_d = adj_cnt_q + AW'(1);
                        end
                    end
                end
                A_REPEAT: begin
                    if (!adj_req) begin
                        adj_st_d  = A_IDLE;
                        adj_cnt_d = '0;
                    end else if (scan_wrap) begin
                        if (adj_cnt_q == REP_LAST) begin
                            adj_tick_d = 1'b1;
                            adj_cnt_d  = '0;
                        end else begin
                            adj_cnt_d = adj_cnt_q + AW'(1);
                        end
                    end
                end
                default: begin
                    adj_st_d  = A_IDLE;
                    adj_cnt_d = '0;
                end
            endcase
        end
    end

    // State and output registers; active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q     <= '0;
            scan_tick_q <= 1'b0;
            scan_cnt_q  <= '0;
            restart_q   <= 1'b0;
            blink_q     <= 1'b0;
            sec_tick_q  <= 1'b0;
            mode_q      <= M_RUN;
            in_set_q    <= 1'b0;
            adj_st_q    <= A_IDLE;
            adj_cnt_q   <= '0;
            adj_prev_q  <= 1'b0;
            adj_tick_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            scan_tick_q <= scan_tick_d;
            scan_cnt_q  <= scan_cnt_d;
            restart_q   <= restart_d;
            blink_q     <= blink_d;
            sec_tick_q  <= sec_tick_d;
            mode_q      <= mode_d;
            in_set_q    <= in_set_d;
            adj_st_q    <= adj_st_d;
            adj_cnt_q   <= adj_cnt_d;
            adj_prev_q  <= adj_prev_d;
            adj_tick_q  <= adj_tick_d;
        end
    end

    assign scan_tick = scan_tick_q;
    assign sec_tick  = sec_tick_q;
    assign blink     = blink_q;
    assign adj_tick  = adj_tick_q;
    assign in_set    = in_set_q;

endmodule

// File: tb/tb_timebase_scheduler.sv
// tb_timebase_scheduler: phase table of input levels with expected scan
// counts, end levels and expected event cycles for sec_tick, adj_tick and
// blink edges, plus a hand-written mid-period reset sequence.
module tb_timebase_scheduler;

    localparam int DIV = 4;
    localparam int NV  = 15;

    logic clk = 1'b0;
    logic rst;
    logic set_mode;
    logic adj_req;
    logic scan_tick;
    logic sec_tick;
    logic blink;
    logic adj_tick;
    logic in_set;

    int   cyc        = 0;
    int   total      = 0;
    int   bad        = 0;
    int   n_scan     = 0;
    logic blink_prev = 1'b0;
    int   exp_sec[$];
    int   exp_adj[$];
    int   exp_blk[$];

    typedef struct packed {
        logic rst_n;
        logic set;
        logic adj;
        int   len;
        int   n_scan;
        int   sec_off;
        int   adj0;
        int   adj1;
        int   adj2;
        int   adj3;
        int   adj4;
        int   blk0;
        int   blk1;
        logic blink_end;
        logic in_set_end;
    } vec_t;

    timebase_scheduler #(
        .SCAN_DIV     (DIV),
        .SCANS_PER_SEC(8),
        .HOLD_SCANS   (4),
        .REPEAT_SCANS (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_mode (set_mode),
        .adj_req  (adj_req),
        .scan_tick(scan_tick),
        .sec_tick (sec_tick),
        .blink    (blink),
        .adj_tick (adj_tick),
        .in_set   (in_set)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic event_seen(input int kind, input string name);
        int want;
        bit have;
        have = 1'b0;
        want = 0;
        case (kind)
            0: if (exp_sec.size() > 0) begin want = exp_sec.pop_front(); have = 1'b1; end
            1: if (exp_adj.size() > 0) begin want = exp_adj.pop_front(); have = 1'b1; end
            default: if (exp_blk.size() > 0) begin want = exp_blk.pop_front(); have = 1'b1; end
        endcase
        total++;
        if (!have) begin
            bad++;
            $display("FAIL %s: unexpected event at cycle %0d, none required", name, cyc);
        end else if (want != cyc) begin
            bad++;
            $display("FAIL %s: event at cycle %0d, required at cycle %0d", name, cyc, want);
        end
    endtask

    task automatic sample_cycle();
        @(negedge clk);
        if (scan_tick) n_scan++;
        if (sec_tick) event_seen(0, "sec_tick");
        if (adj_tick) event_seen(1, "adj_tick");
        if (blink !== blink_prev) event_seen(2, "blink_edge");
        blink_prev = blink;
        if (sec_tick && adj_tick) begin
            total++;
            bad++;
            $display("FAIL tick_overlap: sec_tick=1 adj_tick=1 at cycle %0d, required not both", cyc);
        end
    endtask

    task automatic drain(input string name);
        check({name, "_sec_missing"}, exp_sec.size(), 0);
        check({name, "_adj_missing"}, exp_adj.size(), 0);
        check({name, "_blink_missing"}, exp_blk.size(), 0);
        exp_sec.delete();
        exp_adj.delete();
        exp_blk.delete();
    endtask

    task automatic push_if(input int kind, input int start, input int off);
        if (off >= 0) begin
            case (kind)
                0: exp_sec.push_back(start + off);
                1: exp_adj.push_back(start + off);
                default: exp_blk.push_back(start + off);
            endcase
        end
    endtask

    initial begin
        vec_t        v[NV];
        int          start;
        logic [31:0] got;

        rst      = 1'b0;
        set_mode = 1'b0;
        adj_req  = 1'b0;

        //          rst  set  adj  len  scan sec  adj0 adj1 adj2 adj3 adj4 blk0 blk1 blink in_set
        v[0]  = '{1'b1,1'b0,1'b0, 24,   6,  -1,  -1,  -1,  -1,  -1,  -1,  15,  -1, 1'b1, 1'b0}; // run, first half second
        v[1]  = '{1'b1,1'b0,1'b0, 28,   7,   7,  -1,  -1,  -1,  -1,  -1,   7,  23, 1'b1, 1'b0}; // first sec_tick
        v[2]  = '{1'b1,1'b1,1'b0,100,  25,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  -1, 1'b1, 1'b1}; // SET 100 clks, frozen
        v[3]  = '{1'b1,1'b0,1'b0, 36,   9,  35,  -1,  -1,  -1,  -1,  -1,  19,  35, 1'b1, 1'b0}; // back to RUN
        v[4]  = '{1'b1,1'b1,1'b0,  8,   2,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  -1, 1'b1, 1'b1}; // enter SET
        v[5]  = '{1'b1,1'b1,1'b1,  3,   0,  -1,   0,  -1,  -1,  -1,  -1,  -1,  -1, 1'b1, 1'b1}; // 3-clk press
        v[6]  = '{1'b1,1'b1,1'b0, 13,   4,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  -1, 1'b1, 1'b1}; // release
        v[7]  = '{1'b1,1'b1,1'b1, 40,  10,  -1,   0,  15,  23,  31,  39,  -1,  -1, 1'b1, 1'b1}; // 40-clk hold
        v[8]  = '{1'b1,1'b1,1'b0, 12,   3,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  -1, 1'b1, 1'b1}; // release
        v[9]  = '{1'b1,1'b1,1'b1, 26,   6,  -1,   0,  15,  23,  -1,  -1,  -1,  -1, 1'b1, 1'b1}; // into repeat
        v[10] = '{1'b0,1'b1,1'b1,  1,   0,  -1,  -1,  -1,  -1,  -1,  -1,   0,  -1, 1'b0, 1'b0}; // reset, prescaler at 2
        v[11] = '{1'b1,1'b1,1'b1, 20,   5,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  -1, 1'b0, 1'b1}; // held level, no edge
        v[12] = '{1'b1,1'b1,1'b0,  4,   1,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  -1, 1'b0, 1'b1}; // release
        v[13] = '{1'b1,1'b1,1'b1, 25,   6,  -1,   0,  15,  23,  -1,  -1,  -1,  -1, 1'b0, 1'b1}; // into repeat
        v[14] = '{1'b1,1'b0,1'b1, 40,  10,  34,  -1,  -1,  -1,  -1,  -1,  18,  34, 1'b0, 1'b0}; // drop SET, button held

        repeat (3) @(negedge clk);
        check("reset_scan_tick", 32'(scan_tick), 0);
        check("reset_sec_tick", 32'(sec_tick), 0);
        check("reset_blink", 32'(blink), 0);
        check("reset_adj_tick", 32'(adj_tick), 0);
        check("reset_in_set", 32'(in_set), 0);
        blink_prev = blink;

        for (int i = 0; i < NV; i++) begin
            rst      = v[i].rst_n;
            set_mode = v[i].set;
            adj_req  = v[i].adj;
            start    = cyc + 1;
            push_if(0, start, v[i].sec_off);
            push_if(1, start, v[i].adj0);
            push_if(1, start, v[i].adj1);
            push_if(1, start, v[i].adj2);
            push_if(1, start, v[i].adj3);
            push_if(1, start, v[i].adj4);
            push_if(2, start, v[i].blk0);
            push_if(2, start, v[i].blk1);
            n_scan = 0;
            for (int c = 0; c < v[i].len; c++) sample_cycle();
            check($sformatf("v%0d_scan_count", i), n_scan, v[i].n_scan);
            check($sformatf("v%0d_blink", i), 32'(blink), 32'(v[i].blink_end));
            check($sformatf("v%0d_in_set", i), 32'(in_set), 32'(v[i].in_set_end));
            drain($sformatf("v%0d", i));
        end

        // Mid-period reset pulse: first scan_tick must come SCAN_DIV clocks after it.
        rst      = 1'b0;
        set_mode = 1'b0;
        adj_req  = 1'b0;
        start    = cyc + 1;
        sample_cycle();
        check("midrst_outputs", 32'({scan_tick, sec_tick, blink, adj_tick, in_set}), 0);
        rst = 1'b1;
        got = 32'hFFFF_FFFF;
        for (int c = 0; c < 12 && got == 32'hFFFF_FFFF; c++) begin
            sample_cycle();
            if (scan_tick) got = cyc - start;
        end
        check("midrst_first_scan_latency", got, DIV);
        drain("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
